// File: rtl/tmds_encoder.sv
// DVI/HDMI TMDS 8b/10b channel encoder with running-disparity tracking.
// Define TMDS_ENCODE_PIPE_EN to add a q_m pre-stage (latency 2 instead of 1).
module tmds_encoder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] d,
   input  logic [1:0] c,
   input  logic       den,
   output logic [9:0] q,
   output logic [4:0] disparity
);

   localparam int unsigned DW = 8;
   localparam int unsigned QW = 10;
   localparam int unsigned CW = 5;
   localparam int unsigned NW = 4;

   localparam logic [QW-1:0] CTRL_00 = 10'h354;
   localparam logic [QW-1:0] CTRL_01 = 10'h0AB;
   localparam logic [QW-1:0] CTRL_10 = 10'h154;
   localparam logic [QW-1:0] CTRL_11 = 10'h2AB;

   logic [NW-1:0] n1d;
   logic          xnor_mode;
   logic [DW:0]   qm_c;
   logic [NW-1:0] n1_c;
   logic [NW-1:0] n0_c;

   logic [DW:0]   qm_s;
   logic [NW-1:0] n1_s;
   logic [NW-1:0] n0_s;
   logic          den_s;
   logic [1:0]    c_s;

   logic [QW-1:0] q_nxt;
   logic [CW-1:0] cnt_nxt;
   logic [CW-1:0] diff;
   logic          invert;

   // Transition-minimising stage: choose XOR/XNOR chaining and count ones of q_m.
   always_comb begin
      n1d = '0;
      for (int i = 0; i < int'(DW); i++) begin
         n1d = n1d + NW'(d[i]);
      end
      xnor_mode = (n1d > NW'(4)) || ((n1d == NW'(4)) && !d[0]);

      qm_c    = '0;
      qm_c[0] = d[0];
      for (int i = 1; i < int'(DW); i++) begin
         qm_c[i] = xnor_mode ? ~(qm_c[i-1] ^ d[i]) : (qm_c[i-1] ^ d[i]);
      end
      qm_c[DW] = ~xnor_mode;

      n1_c = '0;
      for (int i = 0; i < int'(DW); i++) begin
         n1_c = n1_c + NW'(qm_c[i]);
      end
      n0_c = NW'(DW) - n1_c;
   end

`ifdef TMDS_ENCODE_PIPE_EN
   // Pre-stage register; reset contents decode as a c=00 control period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qm_s  <= '0;
         n1_s  <= '0;
         n0_s  <= '0;
         den_s <= 1'b0;
         c_s   <= '0;
      end else begin
         qm_s  <= qm_c;
         n1_s  <= n1_c;
         n0_s  <= n0_c;
         den_s <= den;
         c_s   <= c;
      end
   end
`else
   always_comb begin
      qm_s  = qm_c;
      n1_s  = n1_c;
      n0_s  = n0_c;
      den_s = den;
      c_s   = c;
   end
`endif

   // DC-balancing stage; the counter wraps modulo 32 by design.
   always_comb begin
      q_nxt   = q;
      cnt_nxt = disparity;
      diff    = CW'(n1_s) - CW'(n0_s);
      invert  = (!disparity[CW-1] && (n1_s > n0_s)) ||
                ( disparity[CW-1] && (n0_s > n1_s));

      if (!den_s) begin
         cnt_nxt = '0;
         case (c_s)
            2'b00:   q_nxt = CTRL_00;
            2'b01:   q_nxt = CTRL_01;
            2'b10:   q_nxt = CTRL_10;
            default: q_nxt = CTRL_11;
         endcase
      end else if ((disparity == '0) || (n1_s == n0_s)) begin
         q_nxt   = {~qm_s[DW], qm_s[DW], qm_s[DW] ? qm_s[DW-1:0] : ~qm_s[DW-1:0]};
         cnt_nxt = qm_s[DW] ? (disparity + diff) : (disparity - diff);
      end else if (invert) begin
         q_nxt   = {1'b1, qm_s[DW], ~qm_s[DW-1:0]};
         cnt_nxt = disparity + {3'b000, qm_s[DW], 1'b0} - diff;
      end else begin
         q_nxt   = {1'b0, qm_s[DW], qm_s[DW-1:0]};
         cnt_nxt = disparity + diff - {3'b000, ~qm_s[DW], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q         <= CTRL_00;
         disparity <= '0;
      end else begin
         q         <= q_nxt;
         disparity <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: arithmetic reference model, TMDS decoder
// round-trip, and hand-computed literal symbols. Honours TMDS_ENCODE_PIPE_EN.
module tb_tmds_encoder;

`ifdef TMDS_ENCODE_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] d = 8'h00;
   logic [1:0] c = 2'b00;
   logic       den = 1'b0;
   logic [9:0] q;
   logic [4:0] disparity;

   int passed = 0;
   int total  = 0;
   int mcnt   = 0;
   int cyc    = 0;

   typedef struct {
      logic [9:0] q;
      int         disp;
      logic       den;
      logic [1:0] c;
      logic [7:0] d;
   } exp_t;

   exp_t       pipe_q[$];
   logic [9:0] hist_q [0:16383];
   logic [4:0] hist_d [0:16383];

   tmds_encoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .d         (d),
      .c         (c),
      .den       (den),
      .q         (q),
      .disparity (disparity)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
   endtask

   // Reference encoder written from the symbol rules with integer disparity.
   task automatic model(input logic den_i, input logic [1:0] c_i, input logic [7:0] d_i,
                        output logic [9:0] qe);
      logic [7:0] qm;
      logic       par;
      logic       xnor_m;
      int         n1, n0, qm8;
      if (!den_i) begin
         case (c_i)
            2'b00:   qe = 10'h354;
            2'b01:   qe = 10'h0AB;
            2'b10:   qe = 10'h154;
            default: qe = 10'h2AB;
         endcase
         mcnt = 0;
      end else begin
         n1     = $countones(d_i);
         xnor_m = (n1 > 4) || (n1 == 4 && d_i[0] == 1'b0);
         par    = 1'b0;
         // q_m[i] is the parity of d[i:0]; XNOR chaining flips the odd positions.
         for (int i = 0; i < 8; i++) begin
            par   = par ^ d_i[i];
            qm[i] = par ^ (xnor_m && (i % 2 == 1));
         end
         qm8 = xnor_m ? 0 : 1;
         n1  = $countones(qm);
         n0  = 8 - n1;
         if (mcnt == 0 || n1 == n0) begin
            qe   = {~1'(qm8), 1'(qm8), (qm8 == 1) ? qm : ~qm};
            mcnt = mcnt + ((qm8 == 1) ? (n1 - n0) : (n0 - n1));
         end else if ((mcnt > 0 && n1 > n0) || (mcnt < 0 && n0 > n1)) begin
            qe   = {1'b1, 1'(qm8), ~qm};
            mcnt = mcnt + 2 * qm8 + (n0 - n1);
         end else begin
            qe   = {1'b0, 1'(qm8), qm};
            mcnt = mcnt + (n1 - n0) - 2 * (1 - qm8);
         end
         mcnt = ((mcnt + 48) % 32) - 16;
      end
   endtask

   // Standard receiver-side TMDS decoder.
   task automatic tmds_decode(input logic [9:0] s, output logic is_ctl,
                              output logic [1:0] cc, output logic [7:0] dd);
      logic [7:0] v;
      is_ctl = 1'b1;
      cc     = 2'b00;
      dd     = 8'h00;
      case (s)
         10'h354: cc = 2'b00;
         10'h0AB: cc = 2'b01;
         10'h154: cc = 2'b10;
         10'h2AB: cc = 2'b11;
         default: begin
            is_ctl = 1'b0;
            v      = s[9] ? ~s[7:0] : s[7:0];
            dd[0]  = v[0];
            for (int i = 1; i < 8; i++) begin
               dd[i] = s[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
            end
         end
      endcase
   endtask

   task automatic model_reset();
      exp_t e;
      mcnt = 0;
      pipe_q.delete();
      if (LAT == 2) begin
         e.q = 10'h354; e.disp = 0; e.den = 1'b0; e.c = 2'b00; e.d = 8'h00;
         pipe_q.push_back(e);
      end
   endtask

   // One clock of stimulus plus the per-cycle comparison against the model.
   task automatic step(input logic den_i, input logic [1:0] c_i, input logic [7:0] d_i);
      exp_t       e, o;
      logic       isc;
      logic [1:0] cc;
      logic [7:0] dd;
      den = den_i; c = c_i; d = d_i;
      model(den_i, c_i, d_i, e.q);
      e.disp = mcnt; e.den = den_i; e.c = c_i; e.d = d_i;
      pipe_q.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      hist_q[cyc] = q;
      hist_d[cyc] = disparity;
      o = pipe_q.pop_front();
      chk("q", int'(q), int'(o.q));
      chk("disparity", int'($signed(disparity)), o.disp);
      tmds_decode(q, isc, cc, dd);
      if (o.den) begin
         chk("decode_kind", int'(isc), 0);
         chk("decode_data", int'(dd), int'(o.d));
      end else begin
         chk("decode_ctl", int'({isc, cc}), int'({1'b1, o.c}));
      end
   endtask

   // Literal check of the symbol produced by the inputs of step k.
   task automatic lit(input string name, input int k, input logic [9:0] eq, input logic [4:0] ed);
      chk(name, int'(hist_q[k + LAT - 1]), int'(eq));
      chk({name, "_disp"}, int'(hist_d[k + LAT - 1]), int'(ed));
   endtask

   initial begin
      int k;
      // Reset with control input c=01 applied throughout.
      den = 1'b0; c = 2'b01;
      #1 rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("reset_q", int'(q), 10'h354);
         chk("reset_disp", int'(disparity), 0);
      end
      #2 rst_n = 1'b1;
      model_reset();

      k = cyc + 1;
      for (int i = 0; i < 3; i++) step(1'b0, 2'b01, 8'h00);
      lit("ctl01", k, 10'h0AB, 5'h00);

      k = cyc + 1;
      step(1'b1, 2'b00, 8'h00);
      step(1'b1, 2'b00, 8'h00);
      step(1'b0, 2'b00, 8'h00);
      lit("d00_first", k, 10'h100, 5'h18);
      lit("d00_second", k + 1, 10'h3FF, 5'h02);

      k = cyc + 1;
      step(1'b1, 2'b00, 8'hFF);
      step(1'b0, 2'b10, 8'h00);
      step(1'b0, 2'b11, 8'h00);
      step(1'b0, 2'b00, 8'h00);
      lit("dFF", k, 10'h200, 5'h18);
      lit("ctl10", k + 1, 10'h154, 5'h00);
      lit("ctl11", k + 2, 10'h2AB, 5'h00);
      lit("ctl00", k + 3, 10'h354, 5'h00);

      // Short asynchronous reset pulse in the middle of a data burst.
      for (int i = 0; i < 6; i++) step(1'b1, 2'b00, 8'($urandom));
      #2 rst_n = 1'b0;
      #1;
      chk("pulse_q", int'(q), 10'h354);
      chk("pulse_disp", int'(disparity), 0);
      rst_n = 1'b1;
      model_reset();
      k = cyc + 1;
      step(1'b1, 2'b00, 8'h00);
      step(1'b1, 2'b00, 8'h00);
      step(1'b0, 2'b00, 8'h00);
      lit("restart_first", k, 10'h100, 5'h18);
      lit("restart_second", k + 1, 10'h3FF, 5'h02);

      // Random data with periodic blanking.
      for (int i = 0; i < 10000; i++) begin
         if (i % 60 == 0) begin
            for (int j = 0; j < 4; j++) step(1'b0, 2'($urandom_range(0, 3)), 8'($urandom));
         end
         step(1'b1, 2'b00, 8'($urandom));
      end
      step(1'b0, 2'b00, 8'h00);
      step(1'b0, 2'b00, 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/tmds_encoder.md
TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 SHALL have port clk, input, 1, pixel clock; all state updates on posedge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port d, input, 8, pixel data byte for this channel.
REQ-004 SHALL have port c, input, 2, control bits (HSYNC/VSYNC on channel 0, otherwise 0).
REQ-005 SHALL have port den, input, 1, data enable: 1 = encode d, 0 = emit control symbol for c.
REQ-006 SHALL have port q, output, 10, registered TMDS symbol; q[0] is transmitted first.
REQ-007 SHALL have port disparity, output, 5, current running-disparity register (two's complement), for debug/verification.

Function
REQ-008 SHALL compute N1d = popcount(d); XNOR mode if N1d>4, or N1d==4 and d[0]==0; else XOR mode.
REQ-009 SHALL form q_m: q_m[0]=d[0]; q_m[i]=q_m[i-1] XOR/XNOR d[i] for i=1..7; q_m[8]=1 in XOR mode, 0 in XNOR mode.
REQ-010 SHALL, with N1/N0 = ones/zeros of q_m[7:0] and cnt = disparity, take the balanced branch when cnt==0 or N1==N0: q={~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}; cnt += q_m[8] ? (N1-N0) : (N0-N1).
REQ-011 SHALL, else if (cnt>0 and N1>N0) or (cnt<0 and N0>N1), invert: q={1, q_m[8], ~q_m[7:0]}; cnt += 2*q_m[8] + (N0-N1).
REQ-012 SHALL otherwise pass through: q={0, q_m[8], q_m[7:0]}; cnt += (N1-N0) - 2*(~q_m[8]).
REQ-013 SHALL, when den=0, output control symbol c=00 -> 0x354, 01 -> 0x0AB, 10 -> 0x154, 11 -> 0x2AB, and clear cnt to 0 on that same edge.
REQ-014 SHALL hold cnt in a 5-bit signed register with modular arithmetic and no saturation; legal operation keeps it within -16..+15.
REQ-015 SHALL have latency 1 cycle (inputs sampled at edge N appear on q after edge N) when TMDS_ENCODE_PIPE_EN is undefined.
REQ-016 SHALL accept a new input every cycle with no stall; den may toggle on any cycle; the first data symbol after a control period starts from cnt=0.
REQ-017 SHALL update disparity on the same edge as the q it corresponds to.

Reset
REQ-018 SHALL, while rst_n=0, immediately force q=0x354 and disparity=0, independent of clk.
REQ-019 SHALL, on reset asserted mid-stream, discard all pipeline contents; the first symbol after deassertion reflects only inputs sampled after deassertion.
REQ-020 SHALL reset every pipeline register, including the den/c alignment registers (den resets to 0, c to 00).

Configuration
REQ-021 SHALL, when TMDS_ENCODE_PIPE_EN is defined, register q_m, N1, N0, den and c in an extra stage before the disparity stage, giving latency 2 cycles.
REQ-022 SHALL produce, with TMDS_ENCODE_PIPE_EN defined, a q sequence identical to the undefined case, delayed by one cycle.
REQ-023 SHALL, with TMDS_ENCODE_PIPE_EN undefined, compute q_m and the disparity decision combinationally from the inputs, with one register stage.

Verification
REQ-024 SHALL cover: reset, then den=0, c=01 for 3 cycles -> q=0x354 during reset; q=0x0AB from the first edge after deassertion; disparity=0.
REQ-025 SHALL cover: from cnt=0, den=1, d=0x00, two cycles -> q=0x100 (cnt=-8), then q=0x3FF (cnt=+2).
REQ-026 SHALL cover: from cnt=0, den=1, d=0xFF -> q=0x200, disparity=-8 (0x18).
REQ-027 SHALL cover: 10,000 random d with periodic den=0 blanking -> output decodes back to d via the reference TMDS decoder; each blanking symbol resets disparity to 0; disparity never leaves -16..+15.
REQ-028 SHALL cover: rst_n pulsed low for 1 ns mid data burst, asynchronous to clk -> q=0x354 and disparity=0 immediately; clean restart afterwards.
REQ-029 SHALL cover: REQ-025 and REQ-027 repeated with TMDS_ENCODE_PIPE_EN defined -> identical symbol stream, shifted by exactly one cycle.
